// File: rtl/iddmm_pkg.sv
// Shared types and default sizing for the word-serial Montgomery multiplier.
package iddmm_pkg;

  localparam int unsigned K_DEF = 64;
  localparam int unsigned N_DEF = 4;

  // Controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_A = 3'd1,
    QCALC = 3'd2,
    MUL_B = 3'd3,
    SUB   = 3'd4,
    OUT   = 3'd5
  } state_t;

  // Operand selection: (a, b) = (x, y), (x, x) or (P, y)
  typedef enum logic [1:0] {
    MODE_XY  = 2'd0,
    MODE_XX  = 2'd1,
    MODE_PY  = 2'd2,
    MODE_RSV = 2'd3
  } mode_t;

endpackage

// File: rtl/iddmm_word_mac.sv
// Word multiply-accumulate: p = a*b + c + d. Cannot overflow 2K bits.
module iddmm_word_mac
  import iddmm_pkg::*;
#(
  parameter int unsigned K = K_DEF
) (
  input  logic [K-1:0]   a,
  input  logic [K-1:0]   b,
  input  logic [K-1:0]   c,
  input  logic [K-1:0]   d,
  output logic [2*K-1:0] p
);

  localparam int unsigned W2 = 2 * K;

  // Single combinational product plus two addends
  assign p = W2'(a) * W2'(b) + W2'(c) + W2'(d);

endmodule

// File: rtl/iddmm_serial.sv
// Word-serial interleaved Montgomery multiplier: res = a*b*2^(-N*K) mod m.
// Optional final conditional subtraction is enabled with IDDMM_FINAL_SUB_EN;
// without it the result is left in [0, 2m).
module iddmm_serial
  import iddmm_pkg::*;
#(
  parameter int unsigned K      = K_DEF,
  parameter int unsigned N      = N_DEF,
  parameter int unsigned ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        wr_ena,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [K-1:0]      wr_data,
  input  logic [K-1:0]      wr_m1,
  input  logic              task_req,
  input  logic [1:0]        task_mode,
  output logic              task_grant,
  output logic              busy,
  output logic              res_valid,
  output logic [K-1:0]      res_data,
  output logic              res_last,
  output logic              task_end
);

  localparam logic [ADDR_W-1:0] J_MAX = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic [K-1:0]      m1_q, q_q, carry_q, t_hi_q;
  logic              ext_q;
  logic [ADDR_W-1:0] i_q, j_q;
  logic [K-1:0]      x_mem [N];
  logic [K-1:0]      y_mem [N];
  logic [K-1:0]      m_mem [N];
  logic [K-1:0]      p_q   [N];
  logic [K-1:0]      t_lo_q[N];

  logic              j_last, i_last, accept;
  logic [K-1:0]      a_word, b_word, out_word;
  logic [K-1:0]      mac_a, mac_b, mac_c, mac_d, mac_lo, mac_hi;
  logic [2*K-1:0]    mac_p;
  logic [K:0]        top_sum;
  logic              grant_d, busy_d, valid_d, last_d, end_d;
  logic [K-1:0]      data_d;

`ifdef IDDMM_FINAL_SUB_EN
  logic              borrow_q;
  logic [K-1:0]      d_q[N];
  logic [K:0]        sub_diff;
  logic              use_d;
`endif

  assign j_last = (j_q == J_MAX);
  assign i_last = (i_q == J_MAX);
  assign accept = task_req && (state_q == IDLE) && !busy;
  assign mac_lo = mac_p[K-1:0];
  assign mac_hi = mac_p[2*K-1:K];
  assign top_sum = (K+1)'(t_hi_q) + (K+1)'(mac_hi);

  // Operand banks: one write port, asynchronous read; writable only when idle
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && !busy) begin
      if (wr_ena[0]) x_mem[wr_addr] <= wr_data;
      if (wr_ena[1]) y_mem[wr_addr] <= wr_data;
      if (wr_ena[2]) m_mem[wr_addr] <= wr_data;
    end
  end

  // Operand word selection by mode
  always_comb begin
    a_word = (mode_q == MODE_PY) ? p_q[j_q] : x_mem[j_q];
    b_word = (mode_q == MODE_XX) ? x_mem[i_q] : y_mem[i_q];
  end

  // Shared MAC operand routing
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    mac_d = '0;
    case (state_q)
      MUL_A: begin
        mac_a = a_word;
        mac_b = b_word;
        mac_c = t_lo_q[j_q];
        mac_d = carry_q;
      end
      QCALC: begin
        mac_a = t_lo_q[0];
        mac_b = m1_q;
      end
      MUL_B: begin
        mac_a = q_q;
        mac_b = m_mem[j_q];
        mac_c = t_lo_q[j_q];
        mac_d = carry_q;
      end
      default: ;
    endcase
  end

  iddmm_word_mac #(.K(K)) u_mac (
    .a (mac_a),
    .b (mac_b),
    .c (mac_c),
    .d (mac_d),
    .p (mac_p)
  );

`ifdef IDDMM_FINAL_SUB_EN
  // Serial t - m; keep d when no net borrow remains after the top word
  always_comb begin
    sub_diff = (K+1)'(t_lo_q[j_q]) - (K+1)'(m_mem[j_q]) - (K+1)'(borrow_q);
    use_d    = !borrow_q || (t_hi_q != '0);
    out_word = use_d ? d_q[j_q] : t_lo_q[j_q];
  end
`else
  // Unreduced result: low N words of t
  always_comb begin
    out_word = t_lo_q[j_q];
  end
`endif

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    busy_d  = busy;
    valid_d = 1'b0;
    last_d  = 1'b0;
    end_d   = 1'b0;
    data_d  = '0;
    if (accept) begin
      busy_d = 1'b1;
    end else if (task_end) begin
      busy_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_d = 1'b1;
          state_d = MUL_A;
        end
      end
      MUL_A: if (j_last) state_d = QCALC;
      QCALC: state_d = MUL_B;
      MUL_B: begin
        if (j_last) begin
`ifdef IDDMM_FINAL_SUB_EN
          state_d = i_last ? SUB : MUL_A;
`else
          state_d = i_last ? OUT : MUL_A;
`endif
        end
      end
`ifdef IDDMM_FINAL_SUB_EN
      SUB: if (j_last) state_d = OUT;
`endif
      OUT: begin
        valid_d = 1'b1;
        data_d  = out_word;
        last_d  = j_last;
        end_d   = j_last;
        if (j_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      task_grant <= 1'b0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_last   <= 1'b0;
      task_end   <= 1'b0;
    end else begin
      state_q    <= state_d;
      task_grant <= grant_d;
      busy       <= busy_d;
      res_valid  <= valid_d;
      res_data   <= data_d;
      res_last   <= last_d;
      task_end   <= end_d;
    end
  end

  // Accumulator, counters and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_XY;
      m1_q    <= '0;
      q_q     <= '0;
      carry_q <= '0;
      t_hi_q  <= '0;
      ext_q   <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      for (int n = 0; n < int'(N); n++) begin
        t_lo_q[n] <= '0;
        p_q[n]    <= '0;
      end
`ifdef IDDMM_FINAL_SUB_EN
      borrow_q <= 1'b0;
      for (int n = 0; n < int'(N); n++) d_q[n] <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mode_q  <= (task_mode == MODE_RSV) ? MODE_XY : mode_t'(task_mode);
            m1_q    <= wr_m1;
            carry_q <= '0;
            t_hi_q  <= '0;
            ext_q   <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            for (int n = 0; n < int'(N); n++) t_lo_q[n] <= '0;
`ifdef IDDMM_FINAL_SUB_EN
            borrow_q <= 1'b0;
`endif
          end
        end
        MUL_A: begin
          t_lo_q[j_q] <= mac_lo;
          carry_q     <= mac_hi;
          if (j_last) begin
            t_hi_q  <= top_sum[K-1:0];
            ext_q   <= top_sum[K];
            carry_q <= '0;
            j_q     <= '0;
          end else begin
            j_q <= j_q + ONE;
          end
        end
        QCALC: begin
          q_q     <= mac_lo;
          carry_q <= '0;
        end
        MUL_B: begin
          // Low word of j=0 is zero by choice of q; each later word shifts down
          carry_q <= mac_hi;
          if (j_q != '0) t_lo_q[j_q - ONE] <= mac_lo;
          if (j_last) begin
            t_lo_q[J_MAX] <= top_sum[K-1:0];
            t_hi_q        <= K'(top_sum[K]) + K'(ext_q);
            ext_q         <= 1'b0;
            carry_q       <= '0;
            j_q           <= '0;
            i_q           <= i_last ? '0 : i_q + ONE;
          end else begin
            j_q <= j_q + ONE;
          end
        end
`ifdef IDDMM_FINAL_SUB_EN
        SUB: begin
          d_q[j_q] <= sub_diff[K-1:0];
          borrow_q <= sub_diff[K];
          j_q      <= j_last ? '0 : j_q + ONE;
        end
`endif
        OUT: begin
          p_q[j_q] <= out_word;
          j_q      <= j_last ? '0 : j_q + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iddmm_serial.sv
// Randomised self-checking bench for iddmm_serial (K=8, N=2).
// Follows IDDMM_FINAL_SUB_EN for expected latency and result range.
module tb_iddmm_serial;

  localparam int K  = 8;
  localparam int N  = 2;
  localparam int AW = 1;
  localparam int W  = N * K;
`ifdef IDDMM_FINAL_SUB_EN
  localparam int     LAT   = N * (2 * N + 1) + N + 1;
  localparam longint M_VAL = 64'hC3B5;
`else
  localparam int     LAT   = N * (2 * N + 1) + 1;
  localparam longint M_VAL = 64'h3FF1;
`endif

  logic          clk;
  logic          rst;
  logic [2:0]    wr_ena;
  logic [AW-1:0] wr_addr;
  logic [K-1:0]  wr_data;
  logic [K-1:0]  wr_m1;
  logic          task_req;
  logic [1:0]    task_mode;
  logic          task_grant;
  logic          busy;
  logic          res_valid;
  logic [K-1:0]  res_data;
  logic          res_last;
  logic          task_end;

  int            n_tests;
  int            n_fail;
  longint        mx, my, mm, mp;
  logic [K-1:0]  m1_v;

  iddmm_serial #(.K(K), .N(N), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_ena     (wr_ena),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_m1      (wr_m1),
    .task_req   (task_req),
    .task_mode  (task_mode),
    .task_grant (task_grant),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_last   (res_last),
    .task_end   (task_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: a*b*2^-(N*K) mod m by repeated modular halving
  function automatic longint mont(input longint a, input longint b, input longint m);
    longint v;
    v = (a * b) % m;
    for (int k = 0; k < W; k++) v = ((v & 1) != 0) ? (v + m) >> 1 : v >> 1;
    return v;
  endfunction

  // m' such that m*m' = -1 mod 2^K
  function automatic longint calc_m1(input longint m);
    for (longint c = 0; c < (64'd1 << K); c++)
      if (((m * c + 1) % (64'd1 << K)) == 0) return c;
    return 0;
  endfunction

  task automatic load(input int bank, input longint val);
    for (int w = 0; w < N; w++) begin
      @(negedge clk);
      wr_ena  = 3'(1 << bank);
      wr_addr = AW'(w);
      wr_data = K'(val >> (w * K));
    end
    @(negedge clk);
    wr_ena = '0;
    if (bank == 0) mx = val;
    if (bank == 1) my = val;
    if (bank == 2) mm = val;
  endtask

  task automatic run_task(input logic [1:0] mode, input bit inject);
    logic [W-1:0] res;
    logic [1:0]   em;
    longint       a, b, expv;
    int           got, cyc, first, grants;
    em   = (mode == 2'd3) ? 2'd0 : mode;
    a    = (em == 2'd2) ? mp : mx;
    b    = (em == 2'd1) ? mx : my;
    expv = mont(a, b, mm);
    @(negedge clk);
    task_req  = 1'b1;
    task_mode = mode;
    wr_m1     = m1_v;
    @(negedge clk);
    task_req  = 1'b0;
    task_mode = 2'($urandom);
    wr_m1     = K'($urandom);
    check("grant", longint'(task_grant), 1);
    check("busy_on_grant", longint'(busy), 1);
    res = '0; got = 0; cyc = 0; first = -1; grants = 0;
    while (got < N && cyc < LAT + N + 20) begin
      @(negedge clk);
      cyc++;
      task_req = 1'b0;
      wr_ena   = '0;
      if (task_grant) grants++;
      if (res_valid) begin
        if (got == 0) first = cyc;
        res[got*K +: K] = res_data;
        check("res_last", longint'(res_last), longint'(got == N - 1));
        check("task_end", longint'(task_end), longint'(got == N - 1));
        got++;
      end
      if (inject && cyc == 3) begin
        task_req  = 1'b1;
        task_mode = 2'd0;
      end
      if (inject && cyc == 5) begin
        wr_ena  = 3'b111;
        wr_addr = '0;
        wr_data = K'($urandom);
      end
    end
    // Request raised in the task_end cycle must be dropped
    task_req = 1'b1;
    @(negedge clk);
    task_req = 1'b0;
    check("grant_at_end", longint'(task_grant), 0);
    check("extra_word", longint'(res_valid), 0);
    check("busy_after", longint'(busy), 0);
    check("word_count", longint'(got), N);
    check("latency", longint'(first), LAT);
    check("busy_grants", longint'(grants), 0);
`ifdef IDDMM_FINAL_SUB_EN
    check("result", longint'(res), expv);
`else
    check("result_mod", longint'(res) % mm, expv);
    check("result_lt_2m", longint'(longint'(res) < 2 * mm), 1);
`endif
    mp = expv;
  endtask

  task automatic abort_task(input logic [1:0] mode);
    int seen;
    @(negedge clk);
    task_req  = 1'b1;
    task_mode = mode;
    wr_m1     = m1_v;
    @(negedge clk);
    task_req = 1'b0;
    check("abort_grant", longint'(task_grant), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", longint'(busy), 0);
    check("abort_valid", longint'(res_valid), 0);
    rst  = 1'b0;
    seen = 0;
    repeat (LAT + 2 * N + 4) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("abort_words", longint'(seen), 0);
    mp = 0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    wr_ena = '0; wr_addr = '0; wr_data = '0; wr_m1 = '0;
    task_req = 1'b0; task_mode = '0;
    n_tests = 0; n_fail = 0;
    mx = 0; my = 0; mp = 0; mm = M_VAL;
    m1_v = K'(calc_m1(M_VAL));
    repeat (2) @(negedge clk);
    check("rst_grant", longint'(task_grant), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_valid", longint'(res_valid), 0);
    check("rst_last", longint'(res_last), 0);
    check("rst_end", longint'(task_end), 0);
    check("rst_data", longint'(res_data), 0);
    rst = 1'b0;

    load(2, M_VAL);
    load(0, 64'h3C4B);
    load(1, 64'h1234);
    run_task(2'd0, 1'b0);
    load(1, 64'h3C4B);
    run_task(2'd2, 1'b0);
    run_task(2'd1, 1'b0);
    load(0, 64'h0);
    load(1, 64'h1234);
    run_task(2'd0, 1'b1);
    load(0, 64'h3C4B);
    abort_task(2'd0);
    run_task(2'd2, 1'b0);
    run_task(2'd0, 1'b0);
    load(0, 64'h000F);
    load(1, 64'h000F);
    run_task(2'd0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      if ((r % 3) != 2) load(0, longint'($urandom) % mm);
      load(1, longint'($urandom) % mm);
      run_task(2'($urandom_range(0, 3)), 1'(r == 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
